// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Op codes, FSM states and boundary constants.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hffff_ffff;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement negation.
// Used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  assign out = neg ? (~in + {{(W-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer around the unsigned iterative mul/div core.
// Signs are stripped before launch and restored on completion.
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              core_valid,
  output logic              core_mode,
  output logic [XLEN-1:0]   core_a,
  output logic [XLEN-1:0]   core_b,
  input  logic              core_ready,
  input  logic [2*XLEN-1:0] core_out
);

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic              neg_q;
  logic              a_neg, b_neg, r_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   core_res, spec_res;
  logic              is_spec, accept, capture;

  muldiv_negate #(.W(XLEN)) u_neg_a (
    .in(req_a), .neg(a_neg), .out(mag_a)
  );

  muldiv_negate #(.W(XLEN)) u_neg_b (
    .in(req_b), .neg(b_neg), .out(mag_b)
  );

  muldiv_negate #(.W(2*XLEN)) u_neg_p (
    .in(core_out), .neg(neg_q), .out(prod)
  );

  muldiv_negate #(.W(XLEN)) u_neg_q (
    .in(core_out[XLEN-1:0]), .neg(neg_q), .out(quo)
  );

  muldiv_negate #(.W(XLEN)) u_neg_r (
    .in(core_out[2*XLEN-1:XLEN]), .neg(neg_q), .out(rem)
  );

  // Which operands need negating and whether the result does.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    r_neg = 1'b0;
    unique case (1'b1)
      (req_op == OP_MULHSU): begin
        a_neg = req_a[XLEN-1];
        r_neg = req_a[XLEN-1];
      end
      (req_op == OP_REM): begin
        a_neg = req_a[XLEN-1];
        b_neg = req_b[XLEN-1];
        r_neg = req_a[XLEN-1];
      end
      (req_op == OP_MUL) ||
      (req_op == OP_MULH) ||
      (req_op == OP_DIV): begin
        a_neg = req_a[XLEN-1];
        b_neg = req_b[XLEN-1];
        r_neg = req_a[XLEN-1] ^ req_b[XLEN-1];
      end
      default: ;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the core.
  always_comb begin
    is_spec  = 1'b0;
    spec_res = '0;
    unique case (1'b1)
      req_op[2] && (req_b == '0): begin
        is_spec  = 1'b1;
        spec_res = req_op[1] ? req_a : ALL_ONES;
      end
      ((req_op == OP_DIV) || (req_op == OP_REM)) &&
      (req_a == INT_MIN) && (req_b == ALL_ONES): begin
        is_spec  = 1'b1;
        spec_res = req_op[1] ? '0 : INT_MIN;
      end
      default: ;
    endcase
  end

  // Pick the result half once the core has finished.
  always_comb begin
    core_res = prod[XLEN-1:0];
    unique case (1'b1)
      op_q[2] && op_q[1]:
        core_res = rem;
      op_q[2] && !op_q[1]:
        core_res = quo;
      !op_q[2] && (op_q != OP_MUL):
        core_res = prod[2*XLEN-1:XLEN];
      default:
        core_res = prod[XLEN-1:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake strobes.
  always_comb begin
    state_d    = state_q;
    core_valid = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          accept  = 1'b1;
          state_d = is_spec ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          core_valid = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = core_ready ? S_IDLE : S_DRAIN;
        end else if (core_ready) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (core_ready) state_d = S_IDLE;
      end
      S_DONE: begin
        resp_valid = !flush;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall = req_valid & ~resp_valid;

  // Operand, sign and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      core_a    <= '0;
      core_b    <= '0;
      core_mode <= 1'b0;
      resp_data <= '0;
    end else begin
      if (accept) begin
        op_q      <= req_op;
        neg_q     <= r_neg;
        core_a    <= mag_a;
        core_b    <= mag_b;
        core_mode <= req_op[2];
        if (is_spec) resp_data <= spec_res;
      end
      if (capture) resp_data <= core_res;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: behavioural core plus RV32M model.
// Directed vectors with literal expectations and per-cycle checks.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        core_valid;
  logic        core_mode;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_ready = 1'b0;
  logic [63:0] core_out = '0;

  int total = 0;
  int bad = 0;
  bit expect_resp = 1'b0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .stall(stall), .resp_valid(resp_valid),
    .resp_data(resp_data), .core_valid(core_valid),
    .core_mode(core_mode), .core_a(core_a),
    .core_b(core_b), .core_ready(core_ready),
    .core_out(core_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // RV32M reference semantics.
  function automatic logic [31:0] ref_op(
    input logic [2:0] op,
    input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin
        p = {32'd0, a} * {32'd0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff)
          return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff)
          return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x,
                                      input bit sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

  function automatic bit special(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1'b1;
    if ((op == 3'd4 || op == 3'd6) &&
        a == 32'h80000000 && b == 32'hffffffff) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural core: result appears 33 cycles after launch.
  longint cyc = 0;
  longint rdy_cyc = -100;
  logic [63:0] pend = '0;
  int launches = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic last_m = 1'b0;

  always @(negedge clk) begin
    if (rst_n && core_valid) begin
      rdy_cyc = cyc + 33;
      launches++;
      last_a = core_a;
      last_b = core_b;
      last_m = core_mode;
      if (core_mode)
        pend = (core_b == 0) ? 64'd0 :
               {core_a % core_b, core_a / core_b};
      else
        pend = {32'd0, core_a} * {32'd0, core_b};
    end
  end

  always begin
    @(posedge clk);
    #1;
    cyc++;
    core_ready = (cyc == rdy_cyc);
    if (core_ready) core_out = pend;
  end

  // Per-cycle checks of the DUT against the model.
  bit track = 1'b0;
  logic [31:0] ta = '0, tb = '0;
  logic tm = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      track = 1'b0;
    end else begin
      chk("stall", stall, req_valid & ~resp_valid);
      if (resp_valid) begin
        total++;
        if (!expect_resp) begin
          bad++;
          $display("FAIL spurious_resp: got 1 want 0");
        end
        chk("resp_data", resp_data,
            ref_op(req_op, req_a, req_b));
      end
      if (core_valid) begin
        chk("core_a", core_a, mag(req_a,
            req_op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}));
        chk("core_b", core_b, mag(req_b,
            req_op inside {3'd0, 3'd1, 3'd4, 3'd6}));
        chk("core_mode", core_mode, req_op[2]);
        chk("launch_special", special(req_op, req_a, req_b), 0);
        ta = core_a;
        tb = core_b;
        tm = core_mode;
        track = 1'b1;
      end else if (track) begin
        chk("hold_a", core_a, ta);
        chk("hold_b", core_b, tb);
        chk("hold_mode", core_mode, tm);
        if (core_ready) track = 1'b0;
      end
    end
  end

  task automatic wait_resp(output bit got, output int lat,
                           output logic [31:0] d);
    got = 1'b0;
    lat = -1;
    d = '0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = n;
        d = resp_data;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat);
    bit got;
    int lat, l0;
    logic [31:0] d;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    expect_resp = 1'b1;
    l0 = launches;
    wait_resp(got, lat, d);
    chk("resp_seen", got, 1);
    chk("latency", lat, exp_lat);
    chk("result", d, exp);
    chk("launches", launches, l0 + ((exp_lat == 1) ? 0 : 1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    expect_resp = 1'b0;
  endtask

  initial begin
    bit got;
    int lat, n, l0;
    logic [31:0] d;

    #12;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_core_mode", core_mode, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(3'd0, 32'd7, 32'hfffffffd, 32'hffffffeb, 35);
    chk("mul_core_a", last_a, 32'd7);
    chk("mul_core_b", last_b, 32'd3);
    chk("mul_core_mode", last_m, 0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 35);
    run_op(3'd2, 32'hffffffff, 32'd2, 32'hffffffff, 35);
    run_op(3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 35);
    run_op(3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd, 35);
    run_op(3'd6, 32'hfffffff9, 32'd2, 32'hffffffff, 35);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 35);
    chk("divu_core_mode", last_m, 1);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 35);
    run_op(3'd4, 32'd123, 32'd0, 32'hffffffff, 1);
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_op(3'd6, 32'hfffffff9, 32'd0, 32'hfffffff9, 1);
    run_op(3'd4, 32'h80000000, 32'hffffffff, 32'h80000000, 1);
    run_op(3'd6, 32'h80000000, 32'hffffffff, 32'd0, 1);

    // Flush mid-divide, then a MUL waits out the drain.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = 3'd4;
    req_a = 32'd100;
    req_b = 32'd7;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 32'd3;
    req_b = 32'd4;
    expect_resp = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      chk("drain_stall", stall, 1);
      if (core_ready) got = 1'b1;
      n++;
    end
    chk("drain_ready_seen", got, 1);
    wait_resp(got, lat, d);
    chk("drain_resp_seen", got, 1);
    chk("drain_latency", lat, 35);
    chk("drain_result", d, 32'd12);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    expect_resp = 1'b0;

    // Reset while waiting on the core.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = 3'd5;
    req_a = 32'd100;
    req_b = 32'd7;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_data", resp_data, 0);
    chk("arst_core_valid", core_valid, 0);
    chk("arst_core_mode", core_mode, 0);
    chk("arst_core_a", core_a, 0);
    chk("arst_core_b", core_b, 0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", resp_valid, 0);

    // Flush while the special-case result is due.
    l0 = launches;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op = 3'd4;
    req_a = 32'd9;
    req_b = 32'd0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("done_flush_resp", resp_valid, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_flush_launch", launches, l0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the shared unsigned iterative multiply/divide core (32 compute cycles plus 1 output cycle) on behalf of the execute stage.
- Converts RV32M ops to unsigned core operations: takes operand magnitudes, launches the core, waits for its ready, then applies sign correction and selects the result half.
- Holds the pipeline with `stall`.
- Resolves divide-by-zero and signed overflow without using the core, and supports flush, including draining a core that cannot be aborted.

Parameters:
- XLEN, 32, operand/result width; the core is fixed at 32, so only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  M-op present in execute; held stable while stall=1
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a  in  XLEN  rs1 value
- req_b  in  XLEN  rs2 value
- flush  in  1  kill the in-flight op; no response is produced
- stall  out  1  combinational: req_valid & ~resp_valid
- resp_valid  out  1  one-cycle result strobe
- resp_data  out  XLEN  result, valid when resp_valid=1
- core_valid  out  1  one-cycle launch pulse to the core
- core_mode  out  1  0 multiply, 1 divide
- core_a  out  XLEN  unsigned multiplicand or dividend
- core_b  out  XLEN  unsigned multiplier or divisor
- core_ready  in  1  core output cycle
- core_out  in  2*XLEN  [31:0] product low or quotient; [63:32] product high or remainder

Behaviour:
- Reset (asynchronous, active-low, on rst_n; clock clk) forces:
  - state=IDLE
  - resp_valid=0, resp_data=0
  - core_valid=0, core_mode=0, core_a=0, core_b=0
  - all internal registers to 0
- States and transitions:
  - IDLE: if req_valid & ~flush, register the op, magnitudes and sign flags. A special case goes to DONE; otherwise go to ISSUE.
  - ISSUE: core_valid=1. Go to WAIT, or to IDLE if flush (core_valid is suppressed that cycle).
  - WAIT: on core_ready, capture the corrected result and go to DONE. If flush, go to DRAIN.
  - DRAIN: ignore everything until core_ready, then go to IDLE. No response is produced.
  - DONE: resp_valid=1 unless flush; go to IDLE.
- Magnitudes:
  - Signed operand with MSB=1 uses its two's complement.
  - MULHSU: only req_a is signed.
  - MULHU, DIVU, REMU: no negation.
- Result sign:
  - MUL, MULH: a31^b31.
  - MULHSU: a31.
  - DIV: a31^b31.
  - REM: a31.
  - MUL low word may be taken unsigned; both sign conventions give the same low word.
- Product negation is 64-bit two's complement, then the required half is selected.
- Special cases go IDLE->DONE (resp_valid 1 cycle after acceptance) and never launch the core:
  - b==0, DIV/DIVU: result 0xFFFFFFFF.
  - b==0, REM/REMU: result a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Normal latency: request seen in cycle 0, ISSUE in cycle 1, core_ready in cycle 34, resp_valid in cycle 35.
- resp_data holds its value until the next DONE.
- core_a, core_b and core_mode are registered and stable from ISSUE through WAIT.
- A request arriving during DRAIN is stalled and accepted at IDLE.
- core_ready outside WAIT/DRAIN is ignored.
- flush in the same cycle as acceptance in IDLE: the request is not accepted.

Decomposition:
- Shared package `muldiv_pkg`:
  - funct3 op localparams
  - state encodings (IDLE, ISSUE, WAIT, DRAIN, DONE)
  - constants INT_MIN = 0x80000000 and ALL_ONES.
- One sub-module, `muldiv_negate` (parameter W; in, neg -> out = neg ? ~in+1 : in), instanced:
  - at W=32 for operand magnitudes
  - at W=64 for the product
  - at W=32 for quotient and remainder.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> core_a=7, core_b=3, core_mode=0; resp_valid at cycle 35 with 0xFFFFFFEB; stall=1 on cycles 0..34.
- MULH a=b=0x80000000 -> 0x40000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2. All with core_mode=1.
- DIV b=0 -> 0xFFFFFFFF in cycle 1 with core_valid never asserted. REMU a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- flush in cycle 10 of a DIV -> DRAIN; no resp_valid. A new MUL 3*4 presented during DRAIN stays stalled, is accepted after core_ready, and returns 12 with 35-cycle latency from acceptance.
- rst_n low mid-WAIT -> all outputs 0 immediately, state IDLE, no response after release; flush in DONE -> resp_valid stays 0.
